crc_stream_checker: RTL and testbench

CRC_STREAM_CHECKER -- requirements
Module: crc_stream_checker

---
 rtl/crc_chk_pkg.sv | 18 +
 rtl/crc16_ccitt_byte.sv | 20 ++
 rtl/crc_stream_checker.sv | 131 +++++++++++++
 tb/tb_crc_stream_checker.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/crc_chk_pkg.sv
// Shared constants, FSM state encoding and helpers for crc_stream_checker.
package crc_chk_pkg;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CRC_HI  = 2'd2,
    CRC_LO  = 2'd3
  } state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/crc16_ccitt_byte.sv
// One-byte CRC-16/CCITT-FALSE update, MSB-first, combinational.
module crc16_ccitt_byte
  import crc_chk_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  always_comb begin
    c = crc_in ^ {data_in, 8'h00};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/crc_stream_checker.sv
// Frame-based CRC-16/CCITT-FALSE stream checker with gap-timeout abort.
// Optional frame/error statistics enabled by defining CRC_CHK_STATS_EN.
module crc_stream_checker
  import crc_chk_pkg::*;
#(
  parameter int FRAME_LEN   = 16,
  parameter int GAP_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  data,
  output logic        busy,
  output logic        done,
  output logic        crc_ok,
  output logic [15:0] crc_value,
  output logic        abort,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
);

  localparam logic [15:0] LAST_PAYLOAD_CNT = 16'(FRAME_LEN - 3);
  localparam logic [15:0] GAP_LAST         = 16'(GAP_TIMEOUT - 1);

  state_t      state, state_next;
  logic [15:0] crc, crc_step;
  logic [15:0] byte_cnt;
  logic [15:0] gap_cnt;
  logic [7:0]  crc_hi;
  logic        frame_end, timeout, crc_match;

  crc16_ccitt_byte u_crc (
    .crc_in  (crc),
    .data_in (data),
    .crc_out (crc_step)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (timeout) begin
      state_next = IDLE;
    end else if (en) begin
      case (state)
        IDLE:    state_next = (FRAME_LEN == 3) ? CRC_HI : PAYLOAD;
        PAYLOAD: if (byte_cnt == LAST_PAYLOAD_CNT) state_next = CRC_HI;
        CRC_HI:  state_next = CRC_LO;
        CRC_LO:  state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state != IDLE);
    frame_end = (state == CRC_LO) && en;
    timeout   = busy && !en && (gap_cnt == GAP_LAST);
    crc_match = ({crc_hi, data} == crc);
  end

  // crc returns to CRC_INIT on every path into IDLE, so IDLE can seed from it directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc       <= CRC_INIT;
      byte_cnt  <= '0;
      gap_cnt   <= '0;
      crc_hi    <= '0;
      done      <= 1'b0;
      abort     <= 1'b0;
      crc_ok    <= 1'b0;
      crc_value <= '0;
    end else begin
      done  <= 1'b0;
      abort <= 1'b0;
      if (en)        gap_cnt <= '0;
      else if (busy) gap_cnt <= gap_cnt + 16'd1;

      if (timeout) begin
        crc      <= CRC_INIT;
        byte_cnt <= '0;
        gap_cnt  <= '0;
        abort    <= 1'b1;
      end else if (en) begin
        case (state)
          IDLE, PAYLOAD: begin
            crc      <= crc_step;
            byte_cnt <= byte_cnt + 16'd1;
          end
          CRC_HI: crc_hi <= data;
          CRC_LO: begin
            done      <= 1'b1;
            crc_ok    <= crc_match;
            crc_value <= crc;
            crc       <= CRC_INIT;
            byte_cnt  <= '0;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef CRC_CHK_STATS_EN
  logic [15:0] frames, errors;

  always_ff @(posedge clk) begin
    if (rst) begin
      frames <= '0;
      errors <= '0;
    end else begin
      if (frame_end) frames <= sat_inc(frames);
      if ((frame_end && !crc_match) || timeout) errors <= sat_inc(errors);
    end
  end

  always_comb begin
    frame_cnt = frames;
    err_cnt   = errors;
  end
`else
  always_comb begin
    frame_cnt = '0;
    err_cnt   = '0;
  end
`endif

endmodule

// File: tb/tb_crc_stream_checker.sv
// Randomized self-checking bench for crc_stream_checker against a frame-level queue model.
module tb_crc_stream_checker;

  localparam int FL = 11;
  localparam int GT = 4;
`ifdef CRC_CHK_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, en;
  logic [7:0]  data;
  logic        busy, done, crc_ok, abort;
  logic [15:0] crc_value, frame_cnt, err_cnt;

  always #5 clk = ~clk;

  crc_stream_checker #(.FRAME_LEN(FL), .GAP_TIMEOUT(GT)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .data      (data),
    .busy      (busy),
    .done      (done),
    .crc_ok    (crc_ok),
    .crc_value (crc_value),
    .abort     (abort),
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
  );

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  logic [7:0]  m_q[$];
  int          m_gap;
  logic        m_done, m_abort, m_ok;
  logic [15:0] m_val, m_frames, m_errs;
  logic [7:0]  buf_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] crc16(input logic [7:0] b[$], input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      for (int k = 7; k >= 0; k--) begin
        fb = c[15] ^ b[i][k];
        c  = c << 1;
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic model_edge(input logic r, input logic e, input logic [7:0] d);
    if (r) begin
      m_q.delete();
      m_gap = 0; m_done = 0; m_abort = 0; m_ok = 0;
      m_val = 0; m_frames = 0; m_errs = 0;
    end else begin
      m_done  = 0;
      m_abort = 0;
      if (e) begin
        m_q.push_back(d);
        m_gap = 0;
        if (m_q.size() == FL) begin
          m_val    = crc16(m_q, FL - 2);
          m_ok     = ({m_q[FL-2], m_q[FL-1]} == m_val);
          m_done   = 1;
          m_frames = sat(m_frames);
          if (!m_ok) m_errs = sat(m_errs);
          m_q.delete();
        end
      end else if (m_q.size() != 0) begin
        m_gap++;
        if (m_gap == GT) begin
          m_q.delete();
          m_gap   = 0;
          m_abort = 1;
          m_errs  = sat(m_errs);
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [7:0] d);
    rst = r; en = e; data = d;
    @(posedge clk);
    model_edge(r, e, d);
    #1;
    check("busy",      busy,      m_q.size() != 0);
    check("done",      done,      m_done);
    check("abort",     abort,     m_abort);
    check("crc_ok",    crc_ok,    m_ok);
    check("crc_value", crc_value, m_val);
    check("frame_cnt", frame_cnt, STATS_EN ? m_frames : 16'h0);
    check("err_cnt",   err_cnt,   STATS_EN ? m_errs : 16'h0);
  endtask

  task automatic send(input int max_gap);
    for (int i = 0; i < buf_q.size(); i++) begin
      if (max_gap > 0 && $urandom_range(0, 9) < 2)
        repeat ($urandom_range(1, max_gap)) step(0, 0, 8'h00);
      step(0, 1, buf_q[i]);
    end
  endtask

  task automatic load_golden();
    buf_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h29, 8'hB1};
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; data = 8'h00;
    step(1, 0, 8'h00);
    step(1, 1, 8'hA5);
    check("rst_crc_value", crc_value, 16'h0000);
    check("rst_busy", busy, 1'b0);

    // good reference frame
    load_golden();
    send(0);
    check("good_done", done, 1'b1);
    check("good_ok", crc_ok, 1'b1);
    check("good_crc", crc_value, 16'h29B1);
    step(0, 0, 8'h00);

    // corrupted trailer
    buf_q[FL-1] = 8'hB0;
    send(0);
    check("bad_ok", crc_ok, 1'b0);
    check("bad_crc", crc_value, 16'h29B1);
    step(0, 0, 8'h00);

    // back-to-back frames
    load_golden();
    send(0);
    send(0);
    check("b2b_ok", crc_ok, 1'b1);
    step(0, 0, 8'h00);

    // gap timeout: abort after exactly GT idle cycles
    for (int i = 0; i < 5; i++) step(0, 1, buf_q[i]);
    for (int i = 0; i < GT - 1; i++) step(0, 0, 8'h00);
    check("gap_no_abort_early", abort, 1'b0);
    step(0, 0, 8'h00);
    check("gap_abort", abort, 1'b1);
    check("gap_busy", busy, 1'b0);
    step(0, 0, 8'h00);
    step(0, 0, 8'h00);

    // gap one short of timeout keeps the frame
    for (int i = 0; i < 5; i++) step(0, 1, buf_q[i]);
    for (int i = 0; i < GT - 1; i++) step(0, 0, 8'h00);
    for (int i = 5; i < FL; i++) step(0, 1, buf_q[i]);
    check("gap_short_ok", crc_ok, 1'b1);

    // reset mid-frame then a full frame
    for (int i = 0; i < 6; i++) step(0, 1, buf_q[i]);
    step(1, 1, 8'h31);
    send(0);
    check("rst_mid_ok", crc_ok, 1'b1);
    check("rst_mid_done", done, 1'b1);
    step(0, 0, 8'h00);

    // randomized frames, gaps, corruptions and occasional resets
    for (int f = 0; f < 400; f++) begin
      buf_q.delete();
      for (int i = 0; i < FL - 2; i++) buf_q.push_back(8'($urandom));
      begin
        logic [15:0] c;
        c = crc16(buf_q, FL - 2);
        if ($urandom_range(0, 3) == 0) c = c ^ 16'(1 << $urandom_range(0, 15));
        buf_q.push_back(c[15:8]);
        buf_q.push_back(c[7:0]);
      end
      if ($urandom_range(0, 39) == 0) begin
        for (int i = 0; i < $urandom_range(1, FL - 1); i++) step(0, 1, 8'($urandom));
        step(1, 1'($urandom), 8'($urandom));
      end
      send(GT);
      repeat ($urandom_range(0, 2)) step(0, 0, 8'h00);
    end

    repeat (GT + 2) step(0, 0, 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
